// File: rtl/i2c_eeprom_rw_sequencer.sv
// Sequencer that alternates one EEPROM byte write (with ack-polling) and one byte read-back
// through a byte-level I2C master command/response interface.
module i2c_eeprom_rw_sequencer #(
  parameter logic [6:0]  DEV_ADDR   = 7'h50,
  parameter logic [7:0]  MEM_ADDR   = 8'h00,
  parameter int unsigned POLL_LIMIT = 255
) (
  input  logic       ICE_CLK,
  input  logic       RST,
  input  logic       trigger,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic       match,
  output logic [7:0] rd_data,
  output logic [7:0] wr_data,
  output logic       m_cmd_valid,
  input  logic       m_cmd_ready,
  output logic [2:0] m_cmd,
  output logic [7:0] m_wdata,
  input  logic       m_rsp_valid,
  input  logic [7:0] m_rsp_rdata,
  input  logic       m_rsp_nack
);

  localparam logic [2:0] CmdStart    = 3'd0;
  localparam logic [2:0] CmdWrite    = 3'd1;
  localparam logic [2:0] CmdReadNack = 3'd3;
  localparam logic [2:0] CmdStop     = 3'd4;
  localparam logic [7:0] PollLimit   = 8'(POLL_LIMIT);

  typedef enum logic [2:0] {
    StIdle, StIssue, StWait, StAbortIssue, StAbortWait, StFinish
  } state_e;
  typedef enum logic [1:0] {SeqWrite, SeqPoll, SeqRead} seq_e;

  state_e     r_state, w_next_state;
  seq_e       r_seq;
  logic [2:0] r_step;
  logic       r_op_read;
  logic [7:0] r_poll_cnt;
  logic       r_poll_nack;
  logic [7:0] r_rd_tmp, r_rd_data, r_wr_data;
  logic       r_match, r_error;

  logic [2:0] w_cmd;
  logic [7:0] w_wdata, w_wr_prev;
  logic       w_last, w_rsp, w_nack, w_abort, w_poll_fail;

  // Command table: the active sequence and step select the command to present.
  always_comb begin
    w_cmd   = CmdStop;
    w_wdata = 8'h00;
    w_last  = 1'b0;
    unique case (r_seq)
      SeqWrite: begin
        unique case (r_step)
          3'd0:    w_cmd = CmdStart;
          3'd1:    begin w_cmd = CmdWrite; w_wdata = {DEV_ADDR, 1'b0}; end
          3'd2:    begin w_cmd = CmdWrite; w_wdata = MEM_ADDR; end
          3'd3:    begin w_cmd = CmdWrite; w_wdata = r_wr_data; end
          default: w_last = 1'b1;
        endcase
      end
      SeqPoll: begin
        unique case (r_step)
          3'd0:    w_cmd = CmdStart;
          3'd1:    begin w_cmd = CmdWrite; w_wdata = {DEV_ADDR, 1'b0}; end
          default: w_last = 1'b1;
        endcase
      end
      default: begin
        unique case (r_step)
          3'd0:    w_cmd = CmdStart;
          3'd1:    begin w_cmd = CmdWrite; w_wdata = {DEV_ADDR, 1'b0}; end
          3'd2:    begin w_cmd = CmdWrite; w_wdata = MEM_ADDR; end
          3'd3:    w_cmd = CmdStart;
          3'd4:    begin w_cmd = CmdWrite; w_wdata = {DEV_ADDR, 1'b1}; end
          3'd5:    w_cmd = CmdReadNack;
          default: w_last = 1'b1;
        endcase
      end
    endcase
  end

  assign w_rsp       = (r_state == StWait) && m_rsp_valid;
  assign w_nack      = w_rsp && (w_cmd == CmdWrite) && m_rsp_nack;
  assign w_abort     = w_nack && (r_seq != SeqPoll);
  assign w_poll_fail = r_poll_nack && (r_poll_cnt == PollLimit);
  assign w_wr_prev   = r_wr_data - 8'd1;

  always_ff @(posedge ICE_CLK) begin
    if (RST) r_state <= StIdle;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      StIdle:       if (trigger) w_next_state = StIssue;
      StIssue:      if (m_cmd_ready) w_next_state = StWait;
      StWait: begin
        if (w_rsp) begin
          if (w_abort)                                      w_next_state = StAbortIssue;
          else if (!w_last || r_seq == SeqWrite)            w_next_state = StIssue;
          else if (r_seq == SeqPoll && r_poll_nack && !w_poll_fail) w_next_state = StIssue;
          else                                              w_next_state = StFinish;
        end
      end
      StAbortIssue: if (m_cmd_ready) w_next_state = StAbortWait;
      StAbortWait:  if (m_rsp_valid) w_next_state = StFinish;
      StFinish:     w_next_state = StIdle;
      default:      w_next_state = StIdle;
    endcase
  end

  always_comb begin
    busy        = (r_state == StIssue) || (r_state == StWait) ||
                  (r_state == StAbortIssue) || (r_state == StAbortWait);
    done        = (r_state == StFinish);
    m_cmd_valid = (r_state == StIssue) || (r_state == StAbortIssue);
    m_cmd       = CmdStart;
    m_wdata     = 8'h00;
    if (r_state == StIssue) begin
      m_cmd   = w_cmd;
      m_wdata = w_wdata;
    end else if (r_state == StAbortIssue) begin
      m_cmd = CmdStop;
    end
  end

  // Results are committed on the edge into StFinish so they are valid alongside done.
  always_ff @(posedge ICE_CLK) begin
    if (RST) begin
      r_seq       <= SeqWrite;
      r_step      <= 3'd0;
      r_op_read   <= 1'b0;
      r_poll_cnt  <= 8'h00;
      r_poll_nack <= 1'b0;
      r_rd_tmp    <= 8'h00;
      r_rd_data   <= 8'h00;
      r_wr_data   <= 8'h00;
      r_match     <= 1'b0;
      r_error     <= 1'b0;
    end else begin
      if (r_state == StIdle && trigger) begin
        r_error     <= 1'b0;
        r_seq       <= r_op_read ? SeqRead : SeqWrite;
        r_step      <= 3'd0;
        r_poll_cnt  <= 8'h00;
        r_poll_nack <= 1'b0;
      end
      if (w_rsp && !w_abort) begin
        if (w_nack) begin
          r_poll_nack <= 1'b1;
          r_poll_cnt  <= r_poll_cnt + 8'd1;
        end
        if (w_cmd == CmdReadNack) r_rd_tmp <= m_rsp_rdata;
        if (!w_last) begin
          r_step <= r_step + 3'd1;
        end else begin
          r_step <= 3'd0;
          unique case (r_seq)
            SeqWrite: begin
              r_seq       <= SeqPoll;
              r_poll_cnt  <= 8'h00;
              r_poll_nack <= 1'b0;
            end
            SeqPoll: begin
              r_poll_nack <= 1'b0;
              if (w_poll_fail) begin
                r_error <= 1'b1;
              end else if (!r_poll_nack) begin
                r_wr_data <= r_wr_data + 8'd1;
                r_op_read <= 1'b1;
              end
            end
            default: begin
              r_rd_data <= r_rd_tmp;
              r_match   <= (r_rd_tmp == w_wr_prev);
              r_op_read <= 1'b0;
            end
          endcase
        end
      end
      if (r_state == StAbortWait && m_rsp_valid) r_error <= 1'b1;
    end
  end

  assign error   = r_error;
  assign match   = r_match;
  assign rd_data = r_rd_data;
  assign wr_data = r_wr_data;

endmodule

// File: tb/tb_i2c_eeprom_rw_sequencer.sv
// Bench: master/EEPROM responder plus an operation-level model predicting command streams
// and results; every cycle the DUT status is compared against the model.
module tb_i2c_eeprom_rw_sequencer;

  localparam int PollLimit = 255;

  logic       clk = 1'b0, rst = 1'b1, trig = 1'b0;
  logic       busy, done, error, match, m_cmd_valid;
  logic [7:0] rd_data, wr_data, m_wdata;
  logic [2:0] m_cmd;
  logic       m_cmd_ready = 1'b1, m_rsp_valid = 1'b0, m_rsp_nack = 1'b0;
  logic [7:0] m_rsp_rdata = 8'h00;

  always #5 clk = ~clk;

  i2c_eeprom_rw_sequencer #(
    .DEV_ADDR  (7'h50),
    .MEM_ADDR  (8'h00),
    .POLL_LIMIT(PollLimit)
  ) dut (
    .ICE_CLK    (clk),
    .RST        (rst),
    .trigger    (trig),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .match      (match),
    .rd_data    (rd_data),
    .wr_data    (wr_data),
    .m_cmd_valid(m_cmd_valid),
    .m_cmd_ready(m_cmd_ready),
    .m_cmd      (m_cmd),
    .m_wdata    (m_wdata),
    .m_rsp_valid(m_rsp_valid),
    .m_rsp_rdata(m_rsp_rdata),
    .m_rsp_nack (m_rsp_nack)
  );

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Operation-level model state and per-operation knobs
  logic [7:0] md_wr = 0, md_rd = 0, md_mem = 0;
  logic       md_err = 0, md_match = 0, md_op_read = 0;
  logic [7:0] pr_wr, pr_rd, pr_mem;
  logic       pr_err, pr_match, pr_op_read;
  logic [10:0] exp_q[$];
  logic [10:0] rx_log [0:1023];
  int          rx_idx = 0;
  int          k_nack_at = -1, k_poll_nacks = 0, k_stall_at = -1;
  logic [7:0]  k_corrupt = 8'h00;

  typedef enum int {PhIdle, PhRun, PhFin} phase_e;
  phase_e     phase = PhIdle;
  bit         prev_valid = 0, pending = 0, rsp_final = 0, first = 0, cur_write = 0;
  bit         data_pending = 0, rsp_nack_n = 0;
  logic [2:0] prev_cmd = 0;
  logic [7:0] prev_wdata = 0, eeprom = 8'h00, rsp_rd = 8'h00;
  int         rsp_wait = 0, stall_left = 0, polls_nacked = 0;

  logic [10:0] lit1 [8] = '{11'h000, 11'h1A0, 11'h100, 11'h100, 11'h400,
                            11'h000, 11'h1A0, 11'h400};
  logic [10:0] lit2 [7] = '{11'h000, 11'h1A0, 11'h100, 11'h000, 11'h1A1, 11'h300, 11'h400};

  // Expected stream and results of one operation, straight from the protocol description.
  task predict();
    logic [10:0] wl [4];
    logic [10:0] rl [6];
    logic [7:0]  wm1;
    int          n;
    exp_q.delete();
    pr_wr = md_wr; pr_rd = md_rd; pr_mem = md_mem; pr_match = md_match;
    pr_op_read = md_op_read; pr_err = 1'b0;
    if (!md_op_read) begin
      wl = '{11'h000, 11'h1A0, 11'h100, {3'd1, md_wr}};
      if (k_nack_at >= 1 && k_nack_at <= 3) begin
        for (int i = 0; i <= k_nack_at; i++) exp_q.push_back(wl[i]);
        exp_q.push_back(11'h400);
        pr_err = 1'b1;
      end else begin
        for (int i = 0; i < 4; i++) exp_q.push_back(wl[i]);
        exp_q.push_back(11'h400);
        pr_mem = md_wr;
        n = (k_poll_nacks >= PollLimit) ? PollLimit : k_poll_nacks + 1;
        for (int i = 0; i < n; i++) begin
          exp_q.push_back(11'h000); exp_q.push_back(11'h1A0); exp_q.push_back(11'h400);
        end
        if (k_poll_nacks >= PollLimit) pr_err = 1'b1;
        else begin pr_wr = md_wr + 8'd1; pr_op_read = 1'b1; end
      end
    end else begin
      rl = '{11'h000, 11'h1A0, 11'h100, 11'h000, 11'h1A1, 11'h300};
      if (k_nack_at == 1 || k_nack_at == 2 || k_nack_at == 4) begin
        for (int i = 0; i <= k_nack_at; i++) exp_q.push_back(rl[i]);
        exp_q.push_back(11'h400);
        pr_err = 1'b1;
      end else begin
        for (int i = 0; i < 6; i++) exp_q.push_back(rl[i]);
        exp_q.push_back(11'h400);
        wm1 = md_wr - 8'd1;
        pr_rd = md_mem ^ k_corrupt;
        pr_match = (pr_rd == wm1);
        pr_op_read = 1'b0;
      end
    end
  endtask

  task engine_step();
    logic        s_ready, s_rsp, s_xfer, poll_c;
    logic [31:0] act_st, exp_st;
    s_ready = m_cmd_ready;
    s_rsp   = m_rsp_valid;
    act_st  = {12'd0, busy, done, error, wr_data, rd_data, match};
    if (rst) begin
      phase = PhIdle; md_wr = 0; md_rd = 0; md_err = 0; md_match = 0; md_op_read = 0;
      pending = 0; rsp_final = 0; data_pending = 0;
      m_rsp_valid = 1'b0; m_cmd_ready = 1'b1;
      chk("reset_status", act_st, 32'd0);
      chk("reset_cmd", {m_cmd_valid, m_cmd, m_wdata}, 12'd0);
      prev_valid = m_cmd_valid;
      return;
    end
    s_xfer = prev_valid && s_ready && (phase == PhRun);
    first = 0;
    case (phase)
      PhIdle: if (trig) begin
        phase = PhRun; first = 1; predict(); rx_idx = 0; polls_nacked = 0;
        cur_write = !md_op_read; stall_left = 5;
      end
      PhRun: if (s_rsp && rsp_final) begin
        phase = PhFin;
        md_wr = pr_wr; md_rd = pr_rd; md_mem = pr_mem; md_err = pr_err;
        md_match = pr_match; md_op_read = pr_op_read;
      end
      default: phase = PhIdle;
    endcase
    if (s_xfer) begin
      if (rx_idx < 1024) rx_log[rx_idx] = {prev_cmd, prev_wdata};
      if (rx_idx < exp_q.size()) chk("cmd_stream", {prev_cmd, prev_wdata}, exp_q[rx_idx]);
      else chk("cmd_extra", rx_idx, exp_q.size());
      poll_c = cur_write && rx_idx >= 5 && ((rx_idx - 5) % 3 == 1) && polls_nacked < k_poll_nacks;
      rsp_nack_n = (prev_cmd == 3'd1) && (rx_idx == k_nack_at || poll_c);
      if (poll_c) polls_nacked++;
      if (cur_write && rx_idx == 3 && !rsp_nack_n) eeprom = prev_wdata;
      data_pending = cur_write && rx_idx == 3;
      rsp_rd = eeprom ^ k_corrupt;
      rx_idx++; pending = 1; rsp_wait = 1;
      chk("valid_drop", m_cmd_valid, 0);
    end else if (prev_valid && !s_ready) begin
      chk("cmd_hold", {m_cmd_valid, m_cmd, m_wdata}, {1'b1, prev_cmd, prev_wdata});
    end
    case (phase)
      PhIdle:  exp_st = {12'd0, 1'b0, 1'b0, md_err, md_wr, md_rd, md_match};
      PhRun:   exp_st = {12'd0, 1'b1, 1'b0, 1'b0, md_wr, md_rd, md_match};
      default: exp_st = {12'd0, 1'b0, 1'b1, md_err, md_wr, md_rd, md_match};
    endcase
    chk("status", act_st, exp_st);
    if (phase != PhRun) chk("idle_valid", m_cmd_valid, 0);
    if (first) chk("first_start", {m_cmd_valid, m_cmd}, {1'b1, 3'd0});
    if (phase == PhFin) chk("cmd_count", rx_idx, exp_q.size());
    if (phase == PhRun && s_rsp && !rsp_final) chk("next_cmd", m_cmd_valid, 1);
    if (pending && !s_xfer) chk("one_outstanding", m_cmd_valid, 0);
    m_rsp_valid = 1'b0; m_rsp_nack = 1'b0; rsp_final = 0;
    if (pending) begin
      if (rsp_wait == 0) begin
        m_rsp_valid = 1'b1; m_rsp_nack = rsp_nack_n; m_rsp_rdata = rsp_rd;
        pending = 0; data_pending = 0; rsp_final = (rx_idx == exp_q.size());
      end else rsp_wait--;
    end
    if (phase == PhRun && m_cmd_valid && rx_idx == k_stall_at && stall_left > 0) begin
      m_cmd_ready = 1'b0; stall_left--;
    end else m_cmd_ready = 1'b1;
    prev_valid = m_cmd_valid; prev_cmd = m_cmd; prev_wdata = m_wdata;
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #2;
      engine_step();
    end
  end

  task automatic run_op(input int nack_at, input int poll_nacks, input logic [7:0] corrupt,
                        input int stall_at, input bit extra_trig);
    bit got;
    k_nack_at = nack_at; k_poll_nacks = poll_nacks; k_corrupt = corrupt; k_stall_at = stall_at;
    @(negedge clk); trig = 1'b1;
    @(negedge clk); trig = 1'b0;
    got = 0;
    for (int i = 0; i < 6000 && !got; i++) begin
      @(negedge clk);
      trig = extra_trig && (i == 2);
      if (done) begin
        got = 1;
        trig = extra_trig;
        @(negedge clk);
        trig = 1'b0;
      end
    end
    chk("done_seen", got, 1);
    @(negedge clk);
  endtask

  initial begin
    bit seen;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("lit_reset", {busy, done, error, match, rd_data, wr_data, m_cmd_valid, m_cmd, m_wdata},
        32'd0);

    run_op(-1, 0, 8'h00, -1, 0);
    chk("lit_op1_wr", wr_data, 8'h01);
    chk("lit_op1_err", error, 0);
    chk("lit_op1_len", rx_idx, 8);
    for (int i = 0; i < 8; i++) chk("lit_op1_cmd", rx_log[i], lit1[i]);

    run_op(-1, 0, 8'h00, -1, 0);
    chk("lit_op2_rd", rd_data, 8'h00);
    chk("lit_op2_match", match, 1);
    chk("lit_op2_len", rx_idx, 7);
    for (int i = 0; i < 7; i++) chk("lit_op2_cmd", rx_log[i], lit2[i]);

    run_op(-1, 3, 8'h00, -1, 0);
    chk("lit_op3_data", rx_log[3], 11'h101);
    chk("lit_op3_len", rx_idx, 17);
    chk("lit_op3_wr", wr_data, 8'h02);

    run_op(2, 0, 8'h00, -1, 0);
    chk("lit_op4_err", error, 1);
    chk("lit_op4_rd", rd_data, 8'h00);
    chk("lit_op4_stop", rx_log[3], 11'h400);

    run_op(-1, 0, 8'h00, -1, 0);
    chk("lit_op5_err", error, 0);
    chk("lit_op5_rd", {rd_data, 7'd0, match}, {8'h01, 8'h01});

    run_op(-1, 255, 8'h00, -1, 0);
    chk("lit_op6_err", error, 1);
    chk("lit_op6_wr", wr_data, 8'h02);
    chk("lit_op6_len", rx_idx, 770);

    run_op(-1, 0, 8'h00, 3, 1);
    chk("lit_op7_data", rx_log[3], 11'h102);
    chk("lit_op7_wr", {error, wr_data}, 9'h003);

    run_op(-1, 0, 8'h5A, -1, 0);
    chk("lit_op8_rd", {rd_data, 7'd0, match}, {8'h58, 8'h00});

    // Reset while the data byte of a write is outstanding
    k_nack_at = -1; k_poll_nacks = 0; k_corrupt = 8'h00; k_stall_at = -1;
    @(negedge clk); trig = 1'b1;
    @(negedge clk); trig = 1'b0;
    seen = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      seen = data_pending;
    end
    chk("data_wait_seen", seen, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("lit_rst_mid", {busy, done, error, match, rd_data, wr_data, m_cmd_valid, m_cmd, m_wdata},
        32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    run_op(-1, 0, 8'h00, -1, 0);
    chk("lit_op10_data", rx_log[3], 11'h100);
    chk("lit_op10_wr", wr_data, 8'h01);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
